// File: rtl/dualport_ram_pkg.sv
// Shared types and helpers for the simple dual-port RAM: FSM states,
// read-during-write mode constants and the per-lane parity function.
package dualport_ram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

    localparam int RDW_READ_OLD   = 0;
    localparam int RDW_WRITE_THRU = 1;

    // Lanes are zero-extended to 64 bits by the caller; padding zeros leave the XOR unchanged.
    function automatic logic lane_parity(input logic [63:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/dpram_init_ctrl.sv
// INIT/READY sequencer: zero-fills the array after reset, then hands the
// write port and read acceptance over to the user requests.
module dpram_init_ctrl
    import dualport_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NB         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NB-1:0]         wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  init_busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [NB-1:0]         mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  rd_accept
);

    ram_state_e            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] init_addr_reg, init_addr_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT;
            init_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            init_addr_reg <= init_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        init_addr_next = init_addr_reg;
        init_busy      = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = wr_addr;
        mem_be         = wr_be;
        mem_wdata      = wr_data;
        rd_accept      = 1'b0;
        case (state_reg)
            ST_INIT: begin
                init_busy      = 1'b1;
                mem_we         = rst_n;
                mem_addr       = init_addr_reg;
                mem_be         = '1;
                mem_wdata      = '0;
                init_addr_next = init_addr_reg + ADDR_WIDTH'(1);
                if (init_addr_reg == {ADDR_WIDTH{1'b1}})
                    state_next = ST_READY;
            end
            ST_READY: begin
                // A held-low reset must not let user traffic reach the array.
                mem_we    = rst_n & wr_en & (|wr_be);
                rd_accept = rst_n & rd_en;
            end
            default: state_next = ST_INIT;
        endcase
    end

endmodule

// File: rtl/dualport_ram_sync.sv
// Single-clock simple dual-port RAM with byte enables, 1- or 2-cycle read
// pipeline and post-reset zero fill. Optional per-lane parity: RAM_PARITY_EN.
module dualport_ram_sync
    import dualport_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = RDW_READ_OLD
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             init_busy,
    output logic                             par_err
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("dualport_ram_sync: RD_LATENCY must be 1 or 2");
        end
        if ((DATA_WIDTH % BYTE_WIDTH) != 0 || BYTE_WIDTH > 64) begin : g_bad_width
            $error("dualport_ram_sync: DATA_WIDTH must be a multiple of BYTE_WIDTH (<= 64)");
        end
    endgenerate

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_accept;

    dpram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NB         (NB)
    ) u_init_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .init_busy (init_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .rd_accept (rd_accept)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b])
                    mem[mem_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Lanes forwarded from the write port on a same-address collision (write-through only).
    logic                  same_addr;
    logic [NB-1:0]         fwd_lane;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_perr;

    assign same_addr = mem_we && (mem_addr == rd_addr);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_rd_lane
            assign fwd_lane[gi] = (RDW_MODE == RDW_WRITE_THRU) && same_addr && mem_be[gi];
            assign rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = fwd_lane[gi]
                ? mem_wdata[gi*BYTE_WIDTH +: BYTE_WIDTH]
                : mem[rd_addr][gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par, rd_par_stored, rd_par_calc;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_par_lane
            assign wr_par[gi]        = lane_parity(64'(mem_wdata[gi*BYTE_WIDTH +: BYTE_WIDTH]));
            assign rd_par_stored[gi] = fwd_lane[gi] ? wr_par[gi] : par_mem[rd_addr][gi];
            assign rd_par_calc[gi]   = lane_parity(64'(rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b])
                    par_mem[mem_addr][b] <= wr_par[b];
            end
        end
    end

    assign rd_perr = |(rd_par_stored ^ rd_par_calc);
`else
    assign rd_perr = 1'b0;
`endif

    logic [RD_LATENCY-1:0] valid_reg;
    logic [RD_LATENCY-1:0] perr_reg;
    logic [DATA_WIDTH-1:0] data_reg [RD_LATENCY];

    // Data stages only advance with a valid beat so rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= '0;
            perr_reg  <= '0;
            for (int s = 0; s < RD_LATENCY; s++)
                data_reg[s] <= '0;
        end else begin
            valid_reg[0] <= rd_accept;
            if (rd_accept) begin
                data_reg[0] <= rd_word;
                perr_reg[0] <= rd_perr;
            end
            for (int s = 1; s < RD_LATENCY; s++) begin
                valid_reg[s] <= valid_reg[s-1];
                if (valid_reg[s-1]) begin
                    data_reg[s] <= data_reg[s-1];
                    perr_reg[s] <= perr_reg[s-1];
                end
            end
        end
    end

    assign rd_valid = valid_reg[RD_LATENCY-1];
    assign rd_data  = data_reg[RD_LATENCY-1];
    assign par_err  = rd_valid & perr_reg[RD_LATENCY-1];

endmodule

// File: tb/tb_dualport_ram_sync.sv
// Bench for dualport_ram_sync: three instances (read-old/L1, write-through/L1,
// read-old/L2) share one stimulus; per-instance scoreboards check every beat.
module tb_dualport_ram_sync;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic [31:0] rdd  [3];
    logic        rdv  [3];
    logic        busy [3];
    logic        pe   [3];

    always #5 clk = ~clk;

    dualport_ram_sync #(.RDW_MODE(0), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]),
        .rd_valid(rdv[0]), .init_busy(busy[0]), .par_err(pe[0]));

    dualport_ram_sync #(.RDW_MODE(1), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]),
        .rd_valid(rdv[1]), .init_busy(busy[1]), .par_err(pe[1]));

    dualport_ram_sync #(.RDW_MODE(0), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[2]),
        .rd_valid(rdv[2]), .init_busy(busy[2]), .par_err(pe[2]));

    typedef struct {
        logic [31:0] data;
        logic        perr;
        int          due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        re;
        logic [3:0]  raddr;
        logic [31:0] exp_old;
        logic [31:0] exp_thru;
    } vec_t;

    exp_t        q [3][$];
    logic [31:0] last_data [3];
    logic [31:0] model [16];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    vec_t        vt [19];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every beat must match the head of its queue on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (rdv[k] === 1'b1) begin
                    checks++;
                    if (q[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat dut%0d cyc %0d: got rd_valid=1 data=%h, required no beat", k, cyc, rdd[k]);
                    end else begin
                        e = q[k].pop_front();
                        if (rdd[k] !== e.data || pe[k] !== e.perr || cyc != e.due) begin
                            errors++;
                            $display("FAIL read_beat dut%0d cyc %0d: got data=%h par_err=%b, required data=%h par_err=%b at cyc %0d",
                                     k, cyc, rdd[k], pe[k], e.data, e.perr, e.due);
                        end
                        last_data[k] = e.data;
                    end
                end else begin
                    checks++;
                    if (rdv[k] !== 1'b0 || rdd[k] !== last_data[k] || pe[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_hold dut%0d cyc %0d: got valid=%b data=%h par_err=%b, required valid=0 data=%h par_err=0",
                                 k, cyc, rdv[k], rdd[k], pe[k], last_data[k]);
                    end
                    if (q[k].size() > 0 && q[k][0].due <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_beat dut%0d cyc %0d: got rd_valid=0, required data=%h due cyc %0d",
                                 k, cyc, q[k][0].data, q[k][0].due);
                        void'(q[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] be,
                         input logic [31:0] wd, input logic re, input logic [3:0] ra,
                         input logic [31:0] e_old, input logic [31:0] e_thru,
                         input logic perr);
        int acc;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra;
        if (re) begin
            acc = cyc + 1;
            q[0].push_back('{e_old,  perr, acc});
            q[1].push_back('{e_thru, perr, acc});
            q[2].push_back('{e_old,  perr, acc + 1});
        end
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[wa][b*8 +: 8] = wd[b*8 +: 8];
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic read_model(input logic [3:0] a);
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, a, model[a], model[a], 1'b0);
    endtask

    // Reset for one cycle, optionally with a read request that must be dropped,
    // then check init_busy across the zero fill while poking dropped traffic.
    task automatic do_reset(input bit poke);
        @(negedge clk);
        rst_n = 1'b0;
        if (poke) begin rd_en = 1'b1; rd_addr = 4'd3; end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            last_data[k] = '0;
        end
        for (int a = 0; a < 16; a++) model[a] = '0;
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (busy[k] !== (i < 16)) begin
                    errors++;
                    $display("FAIL init_busy dut%0d step %0d: got %b, required %b", k, i, busy[k], (i < 16));
                end
            end
            if (poke && i == 3) begin
                wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'hF; wr_data = 32'hFF;
                rd_en = 1'b1; rd_addr = 4'd5;
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            if (i < 16) @(negedge clk);
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 32'h0};
        vt[1]  = '{1'b1, 4'd3, 4'h5, 32'h11223344, 1'b0, 4'd0, 32'h0, 32'h0};
        vt[2]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd3, 32'hDE22BE44, 32'hDE22BE44};
        vt[3]  = '{1'b1, 4'd7, 4'hF, 32'hA5A5A5A5, 1'b1, 4'd7, 32'h0,        32'hA5A5A5A5};
        vt[4]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd7, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vt[5]  = '{1'b1, 4'd0, 4'hF, 32'd10,       1'b0, 4'd0, 32'h0, 32'h0};
        vt[6]  = '{1'b1, 4'd1, 4'hF, 32'd11,       1'b0, 4'd0, 32'h0, 32'h0};
        vt[7]  = '{1'b1, 4'd2, 4'hF, 32'd12,       1'b0, 4'd0, 32'h0, 32'h0};
        vt[8]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd0, 32'd10, 32'd10};
        vt[9]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd1, 32'd11, 32'd11};
        vt[10] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd2, 32'd12, 32'd12};
        vt[11] = '{1'b1, 4'd4, 4'h0, 32'hFFFFFFFF, 1'b1, 4'd4, 32'h0, 32'h0};
        vt[12] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd4, 32'h0, 32'h0};
        vt[13] = '{1'b1, 4'd5, 4'h8, 32'h12345678, 1'b1, 4'd5, 32'h0,        32'h12000000};
        vt[14] = '{1'b1, 4'd6, 4'hF, 32'hCAFEF00D, 1'b1, 4'd3, 32'hDE22BE44, 32'hDE22BE44};
        vt[15] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd6, 32'hCAFEF00D, 32'hCAFEF00D};
        vt[16] = '{1'b1, 4'd3, 4'h2, 32'h0000AB00, 1'b1, 4'd3, 32'hDE22BE44, 32'hDE22AB44};
        vt[17] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd3, 32'hDE22AB44, 32'hDE22AB44};
        vt[18] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd5, 32'h12000000, 32'h12000000};

        repeat (2) @(posedge clk);
        do_reset(1'b0);

        for (int a = 0; a < 16; a++) read_model(a[3:0]);

        for (int i = 0; i < 19; i++)
            drive(vt[i].we, vt[i].waddr, vt[i].be, vt[i].wdata, vt[i].re, vt[i].raddr,
                  vt[i].exp_old, vt[i].exp_thru, 1'b0);

        for (int a = 0; a < 16; a++) read_model(a[3:0]);

        // Reset lands while the latency-2 read is still in its second stage.
        read_model(4'd3);
        do_reset(1'b1);
        read_model(4'd5);
        for (int a = 0; a < 16; a++) read_model(a[3:0]);

`ifdef RAM_PARITY_EN
        drive(1'b1, 4'd9, 4'hF, 32'h0F0F1234, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        dut0.mem[9][0] = ~dut0.mem[9][0];
        dut1.mem[9][0] = ~dut1.mem[9][0];
        dut2.mem[9][0] = ~dut2.mem[9][0];
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h0F0F1235, 32'h0F0F1235, 1'b1);
        read_model(4'd6);
`endif

        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d: got %0d outstanding beats, required 0", k, q[k].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish before 200000");
        $fatal(1);
    end

endmodule
